// File: rtl/mem_port_sched_if.sv
// Bus bundle between the fetch/LSB requesters, the RAM/IO pins and the port scheduler.
// The master modport is the environment side; slave is the scheduler.
interface mem_port_sched_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              rdy_in;
    logic              clear;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ready;
    logic [31:0]       if_data;
    logic              ls_req;
    logic              ls_wr;
    logic [1:0]        ls_size;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_done;
    logic [31:0]       ls_rdata;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              io_buffer_full;

    modport master (
        output rdy_in, clear, if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
               mem_din, io_buffer_full,
        input  if_ready, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  rdy_in, clear, if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
               mem_din, io_buffer_full,
        output if_ready, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_port_sched.sv
// Arbitrates the single byte-wide RAM/IO port between instruction fetch and the
// load/store buffer, serialising each granted access into per-byte bus cycles.
module mem_port_sched #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned IF_BYTES = 4,
    parameter bit          LS_FIRST = 1'b1
) (
    input logic             clk_in,
    input logic             rst_in,
    mem_port_sched_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

    state_e            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [2:0]        n_q, n_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0][7:0]   wdata_q, wdata_d;
    logic [3:0][7:0]   rbuf_q, rbuf_d;
    logic              is_if_q, is_if_d;
    logic              last_ls_q, last_ls_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              ls_done_q, ls_done_d;
    logic [ADDR_W-1:0] mem_a_q;
    logic [ADDR_W-1:0] bus_a;
    logic              wr_en;
    logic [7:0]        dout;
    logic              stall;
    logic              grant_ls;
    logic              grant_if;
    logic [2:0]        cap_idx;
    logic [2:0]        ls_n;

    always_comb begin
        case (bus.ls_size)
            2'b00:   ls_n = 3'd1;
            2'b01:   ls_n = 3'd2;
            default: ls_n = 3'd4;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        n_d        = n_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        is_if_d    = is_if_q;
        last_ls_d  = last_ls_q;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        if_ready_d = 1'b0;
        ls_done_d  = 1'b0;
        bus_a      = mem_a_q;
        wr_en      = 1'b0;
        dout       = 8'h00;
        cap_idx    = idx_q - 3'd1;
        stall      = (addr_q[17:16] == 2'b11) && bus.io_buffer_full;
        // Round-robin on a tie: the side that did not win last time goes first.
        grant_ls   = bus.ls_req && (!bus.if_req || !last_ls_q);
        grant_if   = bus.if_req && !grant_ls;

        case (state_q)
            StIdle: begin
                if (!bus.clear && grant_ls) begin
                    state_d   = bus.ls_wr ? StWr : StRd;
                    idx_d     = 3'd0;
                    n_d       = ls_n;
                    addr_d    = bus.ls_addr;
                    wdata_d   = bus.ls_wdata;
                    rbuf_d    = '0;
                    is_if_d   = 1'b0;
                    last_ls_d = 1'b1;
                end else if (!bus.clear && grant_if) begin
                    state_d   = StRd;
                    idx_d     = 3'd0;
                    n_d       = 3'(IF_BYTES);
                    addr_d    = bus.if_addr;
                    rbuf_d    = '0;
                    is_if_d   = 1'b1;
                    last_ls_d = 1'b0;
                end
            end
            StRd: begin
                // Address phase for byte idx overlaps the data phase of byte idx-1.
                if (idx_q < n_q) begin
                    bus_a = addr_q + ADDR_W'(idx_q);
                end
                if (idx_q != 3'd0) begin
                    rbuf_d[cap_idx[1:0]] = bus.mem_din;
                end
                idx_d = idx_q + 3'd1;
                if (bus.clear) begin
                    state_d = StIdle;
                end else if (idx_q == n_q) begin
                    state_d = StIdle;
                    if (is_if_q) begin
                        if_data_d  = rbuf_d;
                        if_ready_d = 1'b1;
                    end else begin
                        ls_rdata_d = rbuf_d;
                        ls_done_d  = 1'b1;
                    end
                end
            end
            StWr: begin
                bus_a = addr_q + ADDR_W'(idx_q);
                dout  = wdata_q[idx_q[1:0]];
                if (!stall) begin
                    wr_en = 1'b1;
                    if (idx_q == n_q - 3'd1) begin
                        state_d   = StIdle;
                        ls_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= StIdle;
            idx_q      <= 3'd0;
            n_q        <= 3'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rbuf_q     <= '0;
            is_if_q    <= 1'b0;
            last_ls_q  <= ~LS_FIRST;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
            if_ready_q <= 1'b0;
            ls_done_q  <= 1'b0;
            mem_a_q    <= '0;
        end else if (bus.rdy_in) begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            n_q        <= n_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            is_if_q    <= is_if_d;
            last_ls_q  <= last_ls_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
            if_ready_q <= if_ready_d;
            ls_done_q  <= ls_done_d;
            mem_a_q    <= bus_a;
        end
    end

    // While frozen, keep presenting the last active address so the RAM's read
    // data lines up with the byte index once the port resumes.
    assign bus.mem_a    = bus.rdy_in ? bus_a : mem_a_q;
    assign bus.mem_wr   = bus.rdy_in & wr_en;
    assign bus.mem_dout = dout;
    assign bus.if_ready = if_ready_q & bus.rdy_in;
    assign bus.ls_done  = ls_done_q & bus.rdy_in;
    assign bus.if_data  = if_data_q;
    assign bus.ls_rdata = ls_rdata_q;

endmodule
